// File: rtl/cpmath_mem_pkg.sv
// Shared definitions for the unified word-addressed RAM and its initiator.
package cpmath_mem_pkg;

    localparam int unsigned MEM_DEPTH = 200;
    localparam int unsigned WORD_W    = 32;

    // Instruction opcode field, shared with the RAM image tooling
    localparam int unsigned OPC_MSB = 31;
    localparam int unsigned OPC_LSB = 26;
    localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

    // Bit positions inside the one-hot arbiter winner vector
    localparam int unsigned WIN_D  = 0;
    localparam int unsigned WIN_IF = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mem_state_e;

    // Request payload latched from the winning port
    typedef struct packed {
        logic              is_d;
        logic              we;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

    // Width of a counter that must hold 0..max_streak
    function automatic int unsigned streak_width(input int unsigned max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

    // Extract the opcode field of an instruction word
    function automatic logic [OPC_W-1:0] opcode_of(input logic [WORD_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/mem_master_arb.sv
// Fixed-priority arbiter (data first) with a starvation guard for fetch.
module mem_master_arb
    import cpmath_mem_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 2,
    parameter int unsigned SW         = 2
) (
    input  logic          if_req,
    input  logic          d_req,
    input  logic [SW-1:0] streak,
    output logic [1:0]    win_c,
    output logic [SW-1:0] streak_nxt_c
);

    // Data wins unless fetch has waited through MAX_STREAK data grants
    always_comb begin
        win_c        = '0;
        streak_nxt_c = streak;
        if (if_req && (!d_req || (streak == SW'(MAX_STREAK)))) begin
            win_c[WIN_IF] = 1'b1;
            streak_nxt_c  = '0;
        end else if (d_req) begin
            win_c[WIN_D] = 1'b1;
            if (if_req) begin
                streak_nxt_c = streak + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_master.sv
// Two-port (fetch/data) initiator for the unified RAM; one access in flight.
module mem_master
    import cpmath_mem_pkg::*;
#(
    parameter int unsigned DEPTH      = MEM_DEPTH,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned MAX_STREAK = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        err,
    output logic [31:0] adress,
    output logic [31:0] data,
    output logic        memRead,
    output logic        memWrite,
    input  logic [31:0] memOut
);

    localparam int unsigned SW = streak_width(MAX_STREAK);
    localparam int unsigned CW = 2;

    mem_state_e    state;
    mem_req_t      req_q;
    mem_req_t      req_sel_c;
    logic          oor_q;
    logic          sel_oor_c;
    logic          sel_store_c;
    logic [CW-1:0] wait_cnt;
    logic [SW-1:0] streak;
    logic [SW-1:0] streak_nxt_c;
    logic [1:0]    win_c;

    mem_master_arb #(
        .MAX_STREAK (MAX_STREAK),
        .SW         (SW)
    ) u_arb (
        .if_req       (if_req),
        .d_req        (d_req),
        .streak       (streak),
        .win_c        (win_c),
        .streak_nxt_c (streak_nxt_c)
    );

    // Gather the winning port's fields and classify the access
    always_comb begin
        req_sel_c = '0;
        if (win_c[WIN_IF]) begin
            req_sel_c.is_d = 1'b0;
            req_sel_c.addr = if_addr;
        end else begin
            req_sel_c.is_d  = 1'b1;
            req_sel_c.we    = d_we;
            req_sel_c.addr  = d_addr;
            req_sel_c.wdata = d_wdata;
        end
        sel_oor_c   = (req_sel_c.addr >= 32'(DEPTH));
        sel_store_c = req_sel_c.is_d && req_sel_c.we;
    end

    // Access sequencer: grant and strobe, wait out RAM latency, respond
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            req_q     <= '0;
            oor_q     <= 1'b0;
            wait_cnt  <= '0;
            streak    <= '0;
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
            adress    <= '0;
            data      <= '0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            err       <= 1'b0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|win_c) begin
                        streak <= streak_nxt_c;
                        req_q  <= req_sel_c;
                        oor_q  <= sel_oor_c;
                        if_gnt <= win_c[WIN_IF];
                        d_gnt  <= win_c[WIN_D];
                        adress <= req_sel_c.addr;
                        data   <= sel_store_c ? req_sel_c.wdata : '0;
                        if (!sel_oor_c) begin
                            memWrite <= sel_store_c;
                            memRead  <= !sel_store_c;
                        end
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (oor_q || (req_q.is_d && req_q.we)) begin
                        if (req_q.is_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= '0;
                        end
                        err   <= oor_q;
                        state <= RESP;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_cnt == CW'(READ_LAT - 1)) begin
                        if (req_q.is_d) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= memOut;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= memOut;
                        end
                        state <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Self-checking bench for mem_master with a behavioural RAM and reference memory.
module tb_mem_master;

    localparam int unsigned DEPTH = 200;
    localparam int unsigned LAT   = 1;
    localparam int unsigned LAT3  = 3;
    localparam int unsigned MAXS  = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] adress, data, memOut;
    logic        memRead, memWrite;

    logic        l3_if_req, l3_if_gnt, l3_if_rvalid, l3_d_gnt, l3_d_rvalid, l3_err;
    logic        l3_memRead, l3_memWrite;
    logic [31:0] l3_if_addr, l3_if_rdata, l3_d_rdata, l3_adress, l3_data, l3_memOut;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_master #(.DEPTH(DEPTH), .READ_LAT(LAT), .MAX_STREAK(MAXS)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .err(err),
        .adress(adress), .data(data), .memRead(memRead), .memWrite(memWrite),
        .memOut(memOut)
    );

    mem_master #(.DEPTH(DEPTH), .READ_LAT(LAT3), .MAX_STREAK(MAXS)) u_dut3 (
        .clk(clk), .reset(reset),
        .if_req(l3_if_req), .if_addr(l3_if_addr), .if_gnt(l3_if_gnt),
        .if_rvalid(l3_if_rvalid), .if_rdata(l3_if_rdata),
        .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
        .d_gnt(l3_d_gnt), .d_rvalid(l3_d_rvalid), .d_rdata(l3_d_rdata), .err(l3_err),
        .adress(l3_adress), .data(l3_data), .memRead(l3_memRead), .memWrite(l3_memWrite),
        .memOut(l3_memOut)
    );

    // RAM preload image: fixed program words at 0 and 107, hashed filler elsewhere
    function automatic logic [31:0] init_word(input int unsigned a);
        if (a == 107) return 32'h2002_0069;
        if (a == 0)   return 32'hFC00_006B;
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Behavioural RAM for the READ_LAT=1 instance
    logic [31:0] ram     [DEPTH];
    bit          wr_seen [DEPTH];
    logic [31:0] pipe1   [LAT];
    always @(posedge clk) begin
        if (memWrite && adress < 32'(DEPTH)) begin
            ram[adress[7:0]]     <= data;
            wr_seen[adress[7:0]] <= 1'b1;
        end
        if (memRead && adress < 32'(DEPTH))
            pipe1[0] <= wr_seen[adress[7:0]] ? ram[adress[7:0]] : init_word(int'(adress[7:0]));
        else
            pipe1[0] <= 32'hDEAD_BEEF;
        for (int i = 1; i < int'(LAT); i++) pipe1[i] <= pipe1[i-1];
    end
    assign memOut = pipe1[LAT-1];

    // Read-only RAM for the READ_LAT=3 instance
    logic [31:0] pipe3 [LAT3];
    always @(posedge clk) begin
        if (l3_memRead && l3_adress < 32'(DEPTH))
            pipe3[0] <= init_word(int'(l3_adress[7:0]));
        else
            pipe3[0] <= 32'hDEAD_BEEF;
        for (int i = 1; i < int'(LAT3); i++) pipe3[i] <= pipe3[i-1];
    end
    assign l3_memOut = pipe3[LAT3-1];

    // Reference memory contents as seen by a correct initiator
    logic [31:0] ref_mem [DEPTH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated access from an idle DUT, checked for timing, strobes and response
    task automatic access(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        bit          oor;
        bit          store;
        logic [31:0] exp_rdata;
        int          edges;
        bit          got;
        oor   = (addr >= 32'(DEPTH));
        store = is_d && we;
        if (oor || store) exp_rdata = 32'd0;
        else              exp_rdata = ref_mem[addr[7:0]];
        @(negedge clk);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        @(posedge clk); #1;
        check("gnt",       32'(is_d ? d_gnt : if_gnt), 32'd1);
        check("other_gnt", 32'(is_d ? if_gnt : d_gnt), 32'd0);
        check("adress",    adress, addr);
        check("memWrite",  32'(memWrite), 32'(store && !oor));
        check("memRead",   32'(memRead),  32'(!store && !oor));
        if (store && !oor) check("data", data, wdata);
        d_req  = 1'b0;
        if_req = 1'b0;
        if (store && !oor) ref_mem[addr[7:0]] = wdata;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            got = is_d ? d_rvalid : if_rvalid;
        end
        check("rvalid_lat",   32'(edges), (store || oor) ? 32'd1 : 32'(1 + LAT));
        check("rdata",        is_d ? d_rdata : if_rdata, exp_rdata);
        check("err",          32'(err), 32'(oor));
        check("other_rvalid", 32'(is_d ? if_rvalid : d_rvalid), 32'd0);
        @(posedge clk); #1;
        check("rvalid_pulse", 32'(is_d ? d_rvalid : if_rvalid), 32'd0);
    endtask

    initial begin
        int          streak_m;
        int          grants;
        int          rv_i;
        int          rv_d;
        int          cyc;
        int          gnt_edge;
        bit          exp_i;
        bit          saw_d_rvalid;
        bit          is_d;
        bit          we;
        logic [31:0] a;

        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        l3_if_req = 1'b0; l3_if_addr = '0;

        // Reset state
        @(posedge clk); #1;
        check("reset_outputs",
              32'({if_gnt, if_rvalid, d_gnt, d_rvalid, err, memRead, memWrite}), 32'd0);
        check("reset_adress", adress, 32'd0);
        check("reset_rdata",  d_rdata | if_rdata | data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Store then load back, and a fetch of a preloaded word
        access(1'b1, 1'b1, 32'd105, 32'd5);
        access(1'b1, 1'b0, 32'd105, 32'd0);
        check("load_105_value", d_rdata, 32'd5);
        access(1'b0, 1'b0, 32'd107, 32'd0);
        check("fetch_107_value", if_rdata, 32'h2002_0069);

        // Both ports requesting continuously: fetch gets every (MAXS+1)th grant
        streak_m = 0; grants = 0; rv_i = 0; rv_d = 0; cyc = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'd107;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd50;
        while ((grants < 6 || rv_i + rv_d < 6) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (if_gnt || d_gnt) begin
                exp_i = (streak_m == int'(MAXS));
                check("arb_onehot", 32'(if_gnt && d_gnt), 32'd0);
                check("arb_winner", 32'(if_gnt), 32'(exp_i));
                streak_m = exp_i ? 0 : streak_m + 1;
                grants++;
                if (grants == 6) begin
                    if_req = 1'b0;
                    d_req  = 1'b0;
                end
            end
            if (if_rvalid) begin
                rv_i++;
                check("arb_if_rdata", if_rdata, ref_mem[107]);
            end
            if (d_rvalid) begin
                rv_d++;
                check("arb_d_rdata", d_rdata, ref_mem[50]);
            end
        end
        check("arb_grants",    32'(grants), 32'd6);
        check("arb_if_rvalid", 32'(rv_i), 32'd2);
        check("arb_d_rvalid",  32'(rv_d), 32'd4);
        @(posedge clk); #1;

        // Out-of-range load
        access(1'b1, 1'b0, 32'd200, 32'd0);

        // Reset in the middle of a load, with a fetch pending
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'd105;
        if_req = 1'b1; if_addr = 32'd107;
        @(posedge clk); #1;
        check("rst_pre_d_gnt", 32'(d_gnt), 32'd1);
        d_req = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("rst_async_flags",
              32'({if_gnt, if_rvalid, d_gnt, d_rvalid, err, memRead, memWrite}), 32'd0);
        check("rst_async_adress", adress, 32'd0);
        check("rst_async_rdata",  d_rdata | if_rdata | data, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        gnt_edge = 0; saw_d_rvalid = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk); #1;
            if (d_rvalid) saw_d_rvalid = 1'b1;
            if (if_gnt && gnt_edge == 0) begin
                gnt_edge = e;
                if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        check("rst_no_stale_rvalid", 32'(saw_d_rvalid), 32'd0);
        check("rst_if_regrant", 32'(gnt_edge >= 1 && gnt_edge <= 2), 32'd1);
        cyc = 0;
        while (!if_rvalid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_if_rdata", if_rdata, ref_mem[107]);
        @(posedge clk); #1;

        // READ_LAT=3 build: fetch of address 0
        @(negedge clk);
        l3_if_req = 1'b1; l3_if_addr = 32'd0;
        @(posedge clk); #1;
        check("l3_gnt", 32'(l3_if_gnt), 32'd1);
        check("l3_memRead", 32'(l3_memRead), 32'd1);
        l3_if_req = 1'b0;
        cyc = 0;
        while (!l3_if_rvalid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("l3_rvalid_lat", 32'(cyc), 32'(1 + LAT3));
        check("l3_rdata", l3_if_rdata, 32'hFC00_006B);
        @(posedge clk); #1;

        // Randomised single-port traffic against the reference memory
        for (int n = 0; n < 40; n++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d && 1'($urandom_range(0, 1));
            a    = 32'($urandom_range(0, DEPTH + 15));
            access(is_d, we, a, 32'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_master.md
# mem_master

Two-port initiator for the unified word-addressed RAM: it accepts instruction-fetch and data load/store requests, arbitrates between them, and drives the RAM's `adress`/`data`/`memRead`/`memWrite` port. It collects `memOut` after a fixed read latency and returns it to the winning requester. It sits between the CPU's fetch/memory stages and the RAM, which is clocked by the same `clk`.

## Interface
Parameters:
- `DEPTH`, 200: number of RAM words; valid addresses are 0..DEPTH-1.
- `READ_LAT`, 1: RAM edges from `memRead` sampled to `memOut` valid; legal range 1..4.
- `MAX_STREAK`, 2: consecutive data grants allowed while fetch waits.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held with `if_addr` until `if_gnt`.
- `if_addr`  in  32  fetch word address.
- `if_gnt`  out  1  one-cycle grant pulse for the fetch port.
- `if_rvalid`  out  1  one-cycle pulse; `if_rdata` valid.
- `if_rdata`  out  32  fetched word.
- `d_req`  in  1  data request; held with `d_we`, `d_addr` and `d_wdata` until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data word address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  one-cycle grant pulse for the data port.
- `d_rvalid`  out  1  one-cycle pulse; load data valid, or store acknowledge.
- `d_rdata`  out  32  load data; 0 for a store acknowledge.
- `err`  out  1  one-cycle pulse, coincident with `rvalid`, when the address is >= DEPTH.
- `adress`  out  32  RAM address.
- `data`  out  32  RAM write data.
- `memRead`  out  1  RAM read strobe.
- `memWrite`  out  1  RAM write strobe.
- `memOut`  in  32  RAM read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if either request is high, arbitrate, latch the winner's fields and go to ISSUE.
- Arbitration:
  - `d_req` wins by default.
  - `if_req` wins when the streak counter equals MAX_STREAK.
  - The streak counter increments on each data grant made while `if_req` is high.
  - The streak counter clears on any fetch grant.
- ISSUE, lasting one cycle:
  - Assert the winner's `gnt`.
  - Drive `adress` from the latched address.
  - In range, store: `memWrite`=1 with `data`=wdata, then go to RESP.
  - In range, load or fetch: `memRead`=1, then go to WAIT.
  - Out of range: no strobe, then go to RESP.
- WAIT: count READ_LAT cycles, then capture `memOut` into `rdata` and go to RESP.
- RESP, lasting one cycle:
  - Pulse the winner's `rvalid`.
  - A store acknowledge gives `rdata`=0.
  - An out-of-range access gives `rdata`=0 and `err`=1.
  - Return to IDLE.
- The `rdata` of the idle port holds its last value.
- Strobes are registered and high for exactly one cycle per access; at most one access is in flight.

## Timing
- Request sampled high at the edge ending cycle T: `gnt` and the strobe are high in T+1.
- Load/fetch `rvalid` is high in T+2+READ_LAT.
- Store or out-of-range `rvalid` is high in T+2.
- IDLE is re-entered the cycle after RESP; the next grant comes at the earliest one cycle later.
- A request raised during a busy state waits; it is never dropped, and `gnt` never fires twice for one request.
- Reset low, at any time:
  - State goes to IDLE and the streak counter to 0.
  - `adress`, `data`, `rdata`, `memRead`, `memWrite`, `gnt`, `rvalid` and `err` all go to 0.
  - An in-flight access is abandoned: no `rvalid` is issued for it.
  - Requests still high after reset releases are arbitrated afresh.

## Structure
- Shared package `cpmath_mem_pkg`: the state enum (IDLE, ISSUE, WAIT, RESP), `MEM_DEPTH`=200 and the opcode field constants. Both the RAM and this block import it.
- One sub-module, `mem_master_arb`: the fixed-priority arbiter plus streak counter. Its outputs are the one-hot winner and the counter update.
- The FSM, latches and RAM port drive live in `mem_master`.

## Test plan
- Data store `d_addr`=105, `d_wdata`=5, then load 105: `memWrite` for one cycle with `adress`=105, ack `d_rvalid` at T+2; the load returns `d_rdata`=5 at T+2+READ_LAT.
- Fetch `if_addr`=107 after RAM preload: `if_gnt` at T+1, `if_rvalid` at T+3 (READ_LAT=1) with `if_rdata`=0x20020069.
- Both requests held continuously: grant order D, D, I, D, D, I; no grant is lost and each `rvalid` goes to the matching port.
- `d_addr`=200, load: no strobe, `d_rvalid`=1 with `d_rdata`=0 and `err`=1 at T+2.
- Reset asserted during WAIT: all outputs 0 asynchronously, no `rvalid`; a held `if_req` is granted two cycles after reset release.
- READ_LAT=3 build: a fetch at address 0 returns 0xFC00006B at T+5.
